// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: default widths, reset vector and the PC FSM state type.
package riscv_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HELD = 2'd2
    } pc_state_e;

    // Instruction fetch requires 4-byte aligned addresses.
    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Resolves the redirect request and its target from branch/jal/jalr, fixed priority jalr > jal > branch.
module pc_target_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            branch,
    input  logic            zero,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] target_pc,
    input  logic [XLEN-1:0] jalr_base,
    output logic            req,
    output logic [XLEN-1:0] tgt,
    output logic            tgt_misaligned
);

    logic taken;

    always_comb begin
        taken = branch & zero;
        req   = jalr | jal | taken;
        if (jalr) begin
            tgt = {jalr_base[XLEN-1:1], 1'b0};
        end else begin
            // jal and taken branch share the pc+imm target
            tgt = target_pc;
        end
        tgt_misaligned = req & ~is_word_aligned(tgt[1:0]);
    end

endmodule

// File: rtl/pc_select_unit.sv
// Fetch PC register with redirect handling: one-cycle redirect when free, capture-and-replay under stall.
module pc_select_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch,
    input  logic            zero,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] target_pc,
    input  logic [XLEN-1:0] jalr_base,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            redirect,
    output logic            pending,
    output logic            misalign
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    logic            req;
    logic [XLEN-1:0] tgt;
    logic            tgt_misaligned;

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [XLEN-1:0] cap_q, cap_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            redirect_q, redirect_d;
    logic            pending_q, pending_d;
    logic            misalign_q, misalign_d;

    pc_target_mux #(.XLEN(XLEN)) u_target_mux (
        .branch         (branch),
        .zero           (zero),
        .jal            (jal),
        .jalr           (jalr),
        .target_pc      (target_pc),
        .jalr_base      (jalr_base),
        .req            (req),
        .tgt            (tgt),
        .tgt_misaligned (tgt_misaligned)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cap_d      = cap_q;
        pending_d  = pending_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (req && tgt_misaligned) begin
                    // bad target is reported but otherwise treated as no request
                    misalign_d = 1'b1;
                    if (!stall) pc_d = pc_q + FOUR;
                end else if (stall) begin
                    if (req) begin
                        cap_d     = tgt;
                        pending_d = 1'b1;
                        state_d   = ST_HELD;
                    end
                end else if (req) begin
                    pc_d       = tgt;
                    redirect_d = 1'b1;
                end else begin
                    pc_d = pc_q + FOUR;
                end
            end
            ST_HELD: begin
                // first captured target wins; anything arriving while held is dropped
                if (!stall) begin
                    pc_d       = cap_q;
                    cap_d      = '0;
                    redirect_d = 1'b1;
                    pending_d  = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_BOOT;
                pending_d = 1'b0;
            end
        endcase
        pc_plus4_d    = pc_d + FOUR;
        fetch_valid_d = (state_d != ST_BOOT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + FOUR;
            cap_q         <= '0;
            fetch_valid_q <= 1'b0;
            redirect_q    <= 1'b0;
            pending_q     <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            cap_q         <= cap_d;
            fetch_valid_q <= fetch_valid_d;
            redirect_q    <= redirect_d;
            pending_q     <= pending_d;
            misalign_q    <= misalign_d;
        end
    end

    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_q;
    assign fetch_valid = fetch_valid_q;
    assign redirect    = redirect_q;
    assign pending     = pending_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_select_unit.sv
// Directed plus randomized bench for pc_select_unit against a transaction-level fetch model.
module tb_pc_select_unit;

    logic        clk = 1'b0;
    logic        rst, stall, branch, zero, jal, jalr;
    logic [31:0] target_pc, jalr_base;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, redirect, pending, misalign;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    bit          m_boot, m_held, m_redir, m_mis;
    longint      m_pc, m_cap;

    always #5 clk = ~clk;

    pc_select_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch), .zero(zero),
        .jal(jal), .jalr(jalr), .target_pc(target_pc), .jalr_base(jalr_base),
        .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
        .redirect(redirect), .pending(pending), .misalign(misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},          pc,                    32'(m_pc));
        chk({tag, ".pc_plus4"},    pc_plus4,              32'((m_pc + 4) % 64'h1_0000_0000));
        chk({tag, ".fetch_valid"}, {31'd0, fetch_valid},  {31'd0, !m_boot});
        chk({tag, ".redirect"},    {31'd0, redirect},     {31'd0, m_redir});
        chk({tag, ".pending"},     {31'd0, pending},      {31'd0, m_held});
        chk({tag, ".misalign"},    {31'd0, misalign},     {31'd0, m_mis});
    endtask

    task automatic model_reset();
        m_boot = 1; m_held = 0; m_cap = 0; m_pc = 0; m_redir = 0; m_mis = 0;
    endtask

    // One clock of fetch behaviour derived from the request rules, using integer arithmetic.
    task automatic model_step();
        longint want;
        bit     asked;
        m_redir = 0;
        m_mis   = 0;
        if (m_boot) begin
            m_boot = 0;
            return;
        end
        asked = jalr || jal || (branch && zero);
        want  = jalr ? longint'(jalr_base) - (longint'(jalr_base) % 2) : longint'(target_pc);
        if (m_held) begin
            if (!stall) begin
                m_pc = m_cap; m_held = 0; m_redir = 1;
            end
            return;
        end
        if (asked && (want % 4) != 0) begin
            m_mis = 1;
            asked = 0;
        end
        if (stall) begin
            if (asked) begin m_cap = want; m_held = 1; end
        end else if (asked) begin
            m_pc = want; m_redir = 1;
        end else begin
            m_pc = (m_pc + 4) % 64'h1_0000_0000;
        end
    endtask

    task automatic idle_inputs();
        stall = 0; branch = 0; zero = 0; jal = 0; jalr = 0; target_pc = '0; jalr_base = '0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1;
        #1 model_reset();
        check_all(tag);
        #2 rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        model_reset();
        #1 check_all("reset");
        chk("reset.pc_const", pc, 32'h0);
        #2 rst = 0;

        // boot then sequential fetch: 0 (invalid), 0, 4, 8
        step("boot");
        chk("boot.pc_const", pc, 32'h0);
        step("seq1");
        step("seq2");
        chk("seq2.pc_const", pc, 32'h8);
        step("seq3");
        step("seq4");
        chk("at10", pc, 32'h10);

        // taken branch
        branch = 1; zero = 1; target_pc = 32'h100;
        step("br_taken");
        chk("br_taken.pc_const", pc, 32'h100);
        chk("br_taken.redir_const", {31'd0, redirect}, 32'd1);
        idle_inputs();
        step("br_after");
        // back to 0x10 then not-taken branch
        jal = 1; target_pc = 32'h10;
        step("jal10");
        idle_inputs(); branch = 1; zero = 0; target_pc = 32'h100;
        step("br_nt");
        chk("br_nt.pc_const", pc, 32'h14);

        // jalr beats jal, LSB cleared
        idle_inputs(); jalr = 1; jal = 1; jalr_base = 32'h201; target_pc = 32'h300;
        step("jalr_prio");
        chk("jalr_prio.pc_const", pc, 32'h200);

        // stalled redirect capture, first wins
        idle_inputs(); stall = 1; jal = 1; target_pc = 32'h80;
        step("stall1");
        target_pc = 32'h90;
        step("stall2");
        chk("stall2.pc_const", pc, 32'h200);
        idle_inputs();
        step("release");
        chk("release.pc_const", pc, 32'h80);
        step("release_after");

        // misaligned target
        jal = 1; target_pc = 32'h20;
        step("jal20");
        target_pc = 32'h102;
        step("misalign");
        chk("misalign.pc_const", pc, 32'h24);
        idle_inputs();
        step("misalign_after");

        // PC wraparound
        jal = 1; target_pc = 32'hFFFF_FFF8;
        step("jal_top");
        idle_inputs();
        step("top_fc");
        step("wrap");
        chk("wrap.pc_const", pc, 32'h0);

        // reset while HELD drops the captured target
        stall = 1; jal = 1; target_pc = 32'h400;
        step("hold400");
        idle_inputs();
        async_reset("rst_held");
        step("rst_boot");
        step("rst_run");
        chk("rst_run.pc_const", pc, 32'h4);

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            stall     = ($urandom_range(0, 99) < 30);
            branch    = ($urandom_range(0, 99) < 30);
            zero      = $urandom_range(0, 1) == 1;
            jal       = ($urandom_range(0, 99) < 15);
            jalr      = ($urandom_range(0, 99) < 10);
            target_pc = $urandom;
            jalr_base = $urandom;
            if ($urandom_range(0, 99) < 85) target_pc[1:0] = 2'b00;
            if ($urandom_range(0, 99) < 85) jalr_base[1] = 1'b0;
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
            else step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
